series_sum: RTL and testbench



---
 rtl/series_sum_pkg.sv | 13 +
 rtl/series_sum_acc.sv | 40 ++++
 rtl/series_sum.sv | 82 ++++++++
 tb/tb_series_sum.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/series_sum_pkg.sv
// Shared types for the series_sum accumulator: status encoding and its width.
package series_sum_pkg;

    localparam int STATUS_W = 3;

    typedef enum logic [STATUS_W-1:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        DONE = 3'd2,
        OVF  = 3'd3
    } status_e;

endpackage

// File: rtl/series_sum_acc.sv
// W-bit accumulator with synchronous clear, enable and carry-out of the pending add.
module series_sum_acc #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] addend_i,
    output logic [W-1:0] acc_o,
    output logic         carry_o
);

    logic [W-1:0] acc_q, acc_d;
    logic [W:0]   add_full;

    // One extra bit on the adder exposes the carry out of the W-bit wrap-around sum.
    assign add_full = {1'b0, acc_q} + {1'b0, addend_i};
    assign carry_o  = en_i & add_full[W];
    assign acc_o    = acc_q;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = add_full[W-1:0];
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/series_sum.sv
// Sums N_ITEMS consecutive items after a one-cycle request; reports DONE or OVF with the W-bit sum.
module series_sum
    import series_sum_pkg::*;
#(
    parameter int N_ITEMS = 10,
    parameter int W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sum_request,
    input  logic [W-1:0]        item,
    output logic [STATUS_W-1:0] status,
    output logic                busy,
    output logic [W-1:0]        sum
);

    localparam int CNT_W = $clog2(N_ITEMS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_ITEMS - 1);

    status_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             acc_clr;
    logic             acc_en;
    logic             carry;
    logic [W-1:0]     acc;

    assign acc_en = (state_q == RUN);

    series_sum_acc #(.W(W)) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (acc_clr),
        .en_i     (acc_en),
        .addend_i (item),
        .acc_o    (acc),
        .carry_o  (carry)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        acc_clr = 1'b0;
        case (state_q)
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                ovf_d = ovf_q | carry;
                // The final add's own carry must count toward the verdict.
                if (cnt_q == LAST_IDX) begin
                    state_d = (ovf_q | carry) ? OVF : DONE;
                end
            end
            default: begin
                if (sum_request) begin
                    acc_clr = 1'b1;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign status = state_q;
    assign busy   = (state_q == RUN);
    assign sum    = acc;

endmodule

// File: tb/tb_series_sum.sv
// Self-checking bench for series_sum: directed scenarios plus random runs against an arithmetic model.
module tb_series_sum;
    import series_sum_pkg::*;

    localparam int N = 10;
    localparam int W = 32;

    typedef logic [W-1:0] series_t [N];

    logic                clk;
    logic                rst;
    logic                sum_request;
    logic [W-1:0]        item;
    logic [STATUS_W-1:0] status;
    logic                busy;
    logic [W-1:0]        sum;

    int tests_run;
    int tests_failed;

    series_sum #(.N_ITEMS(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .sum_request (sum_request),
        .item        (item),
        .status      (status),
        .busy        (busy),
        .sum         (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are read 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: true sum of the series; overflow means it did not fit in W bits.
    function automatic void model(input series_t s, output logic [W-1:0] exp_sum, output status_e exp_st);
        logic [63:0] total;
        total = 64'd0;
        for (int i = 0; i < N; i++) total += 64'(s[i]);
        exp_sum = total[W-1:0];
        exp_st  = (total >= (64'd1 << W)) ? OVF : DONE;
    endfunction

    task automatic run_series(input string name, input series_t s,
                              input int pulse_a, input int pulse_b, input bit hold_req);
        logic [W-1:0] exp_sum;
        status_e      exp_st;
        sum_request = 1'b1;
        item        = $urandom;
        tick();
        sum_request = hold_req;
        check({name, "_acc_busy"}, 64'(busy), 64'd1);
        check({name, "_acc_status"}, 64'(status), 64'(RUN));
        check({name, "_acc_sum"}, 64'(sum), 64'd0);
        for (int i = 0; i < N; i++) begin
            item        = s[i];
            sum_request = hold_req || (i == pulse_a) || (i == pulse_b);
            tick();
            if (i < N - 1) check({name, "_run_busy"}, 64'(busy), 64'd1);
        end
        sum_request = hold_req;
        model(s, exp_sum, exp_st);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_status"}, 64'(status), 64'(exp_st));
        check({name, "_sum"}, 64'(sum), 64'(exp_sum));
    endtask

    initial begin
        series_t      s_inc, s_ovf, s_two, s_rnd;
        logic [W-1:0] hold_sum;
        logic [2:0]   hold_st;

        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        sum_request  = 1'b1;
        item         = 32'hDEAD_BEEF;

        for (int i = 0; i < N; i++) begin
            s_inc[i] = W'(i + 1);
            s_two[i] = W'(2);
            s_ovf[i] = '0;
        end
        s_ovf[0] = 32'hFFFF_FFFF;
        s_ovf[1] = 32'h1;

        // Reset wins over a simultaneous request.
        tick();
        tick();
        check("reset_status", 64'(status), 64'(IDLE));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        rst         = 1'b0;
        sum_request = 1'b0;
        tick();
        check("idle_stays", 64'(status), 64'(IDLE));

        run_series("inc", s_inc, -1, -1, 1'b0);
        check("inc_const_sum", 64'(sum), 64'h37);
        run_series("ovf", s_ovf, -1, -1, 1'b0);
        check("ovf_const_status", 64'(status), 64'(OVF));
        run_series("ignored_req", s_inc, 2, 6, 1'b0);

        // Abort mid-run with reset after five items.
        sum_request = 1'b1;
        tick();
        sum_request = 1'b0;
        for (int i = 0; i < 5; i++) begin
            item = s_inc[i];
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_status", 64'(status), 64'(IDLE));
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        run_series("after_abort", s_inc, -1, -1, 1'b0);

        // Request held high: result lives one cycle, then a new run starts.
        run_series("b2b_first", s_inc, -1, -1, 1'b1);
        run_series("b2b_second", s_two, -1, -1, 1'b1);
        check("b2b_second_const", 64'(sum), 64'h14);
        sum_request = 1'b0;

        // Result holds while the item bus wanders and no request arrives.
        hold_sum = sum;
        hold_st  = status;
        check("hold_base_status", 64'(hold_st), 64'(DONE));
        for (int c = 0; c < 20; c++) begin
            item = $urandom;
            tick();
            check("hold_sum", 64'(sum), 64'(hold_sum));
            check("hold_status", 64'(status), 64'(hold_st));
        end

        // Random runs; shifting the items varies how often overflow happens.
        for (int r = 0; r < 12; r++) begin
            int sh;
            sh = $urandom_range(0, 5);
            for (int i = 0; i < N; i++) s_rnd[i] = $urandom >> sh;
            if (r % 4 == 3) s_rnd[N-1] = 32'hFFFF_FFFF;
            run_series("rnd", s_rnd, int'($urandom_range(0, N)), -1, 1'b0);
            if ($urandom_range(0, 2) == 0) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
